// File: rtl/mem_ack_arbiter_if.sv
// ACK bus between the requesting modules and mem_ack_arbiter.
// The master side drives requests. The slave side is the arbiter, which returns grants and the broadcast.
interface mem_ack_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*ID_W-1:0] req_id;
    logic [N_REQ-1:0]      req_ready;
    logic                  ack_valid;
    logic [ID_W-1:0]       ack_id;

    modport master (
        output req_valid, req_id,
        input  req_ready, ack_valid, ack_id
    );

    modport slave (
        input  req_valid, req_id,
        output req_ready, ack_valid, ack_id
    );
endinterface

// File: rtl/mem_ack_arbiter.sv
// Round-robin arbiter for the shared ACK bus: grant one requester, then broadcast its ID for one cycle.
// Optional macro MEM_ACK_ID_CHECK_EN: a transferred ID must match its slot index, otherwise err is set and the broadcast is suppressed.
module mem_ack_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_ack_arbiter_if.slave   bus,
    output logic               busy,
    output logic               err
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BCAST = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic               ack_valid_q, ack_valid_d;
    logic [ID_W-1:0]    ack_id_q, ack_id_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               any_req;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [PTR_W-1:0]   ptr_next;
`ifdef MEM_ACK_ID_CHECK_EN
    logic [ID_W-1:0]    win_exp_id;
    logic               id_bad;
`endif

    assign any_req = |bus.req_valid;

    // Round-robin pick: first search slots at or above ptr, then wrap to the low slots.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && (PTR_W'(i) >= ptr_q) && bus.req_valid[i]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && bus.req_valid[i]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(i);
            end
        end
    end

    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
`ifdef MEM_ACK_ID_CHECK_EN
        win_exp_id = '0;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (win_q == PTR_W'(i)) begin
                win_valid = bus.req_valid[i];
                win_id    = bus.req_id[i*ID_W +: ID_W];
`ifdef MEM_ACK_ID_CHECK_EN
                win_exp_id = ID_W'(i);
`endif
            end
        end
    end

`ifdef MEM_ACK_ID_CHECK_EN
    assign id_bad = (win_id != win_exp_id);
`endif

    assign ptr_next = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (any_req) state_d = GRANT;
            GRANT: begin
                if (!win_valid) begin
                    state_d = IDLE;
                end else begin
`ifdef MEM_ACK_ID_CHECK_EN
                    state_d = id_bad ? IDLE : BCAST;
`else
                    state_d = BCAST;
`endif
                end
            end
            BCAST:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A withdrawn grant leaves ptr alone, so the same slot wins again if it re-requests.
    always_comb begin
        ptr_d       = ptr_q;
        win_d       = win_q;
        ready_d     = '0;
        ack_valid_d = 1'b0;
        ack_id_d    = ack_id_q;
        err_d       = err_q;
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    win_d = pick_idx;
                    for (int i = 0; i < N_REQ; i++) begin
                        ready_d[i] = (pick_idx == PTR_W'(i));
                    end
                end
            end
            GRANT: begin
                if (win_valid) begin
                    ptr_d = ptr_next;
`ifdef MEM_ACK_ID_CHECK_EN
                    if (id_bad) begin
                        err_d = 1'b1;
                    end else begin
                        ack_valid_d = 1'b1;
                        ack_id_d    = win_id;
                    end
`else
                    ack_valid_d = 1'b1;
                    ack_id_d    = win_id;
`endif
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            win_q       <= '0;
            ready_q     <= '0;
            ack_valid_q <= 1'b0;
            ack_id_q    <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            ready_q     <= ready_d;
            ack_valid_q <= ack_valid_d;
            ack_id_q    <= ack_id_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.ack_valid = ack_valid_q;
    assign bus.ack_id    = ack_id_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_ack_arbiter.sv
// Directed bench for mem_ack_arbiter: reset, single grant, rotation, withdrawal, ID handling, reset during broadcast.
// Outputs are sampled 1 ns after each rising edge, and inputs are changed at the same point.
module tb_mem_ack_arbiter;
    logic clk;
    logic rst_n;
    logic busy;
    logic err;
    int   checks;
    int   failures;
    logic [3:0] vmask;

    mem_ack_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

    mem_ack_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] ids);
        bus.req_valid = valid;
        bus.req_id    = ids;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_ready,
                               input logic exp_av, input logic [1:0] exp_id,
                               input logic exp_busy, input logic exp_err);
        checks++;
        assert (bus.req_ready === exp_ready) else begin
            failures++;
            $error("[TB] FAIL %s.ready observed=%b expected=%b", tag, bus.req_ready, exp_ready);
        end
        checks++;
        assert (bus.ack_valid === exp_av) else begin
            failures++;
            $error("[TB] FAIL %s.ack_valid observed=%b expected=%b", tag, bus.ack_valid, exp_av);
        end
        if (exp_av) begin
            checks++;
            assert (bus.ack_id === exp_id) else begin
                failures++;
                $error("[TB] FAIL %s.ack_id observed=%0d expected=%0d", tag, bus.ack_id, exp_id);
            end
        end
        checks++;
        assert (busy === exp_busy) else begin
            failures++;
            $error("[TB] FAIL %s.busy observed=%b expected=%b", tag, busy, exp_busy);
        end
        checks++;
        assert (err === exp_err) else begin
            failures++;
            $error("[TB] FAIL %s.err observed=%b expected=%b", tag, err, exp_err);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held three cycles while everyone requests.
        rst_n = 1'b0;
        applyStimulus(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0});
        tick(); tick(); tick();
        checkOutput("reset", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("idle", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // Single request from slot 2.
        applyStimulus(4'b0100, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("single_grant", 4'b0100, 1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("single_ack", 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("single_done", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // Rotation from a fresh pointer with all slots requesting.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vmask = 4'b1111;
        applyStimulus(vmask, {2'd3, 2'd2, 2'd1, 2'd0});
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("rot_grant", 4'(1 << k), 1'b0, 2'd0, 1'b1, 1'b0);
            tick();
            checkOutput("rot_ack", 4'b0000, 1'b1, 2'(k), 1'b1, 1'b0);
            vmask[k] = 1'b0;
            applyStimulus(vmask, {2'd3, 2'd2, 2'd1, 2'd0});
            tick();
            checkOutput("rot_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        applyStimulus(4'b0001, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("wrap_grant0", 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("wrap_ack0", 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();

        // Withdrawal by slot 1 during its grant, then ptr must still favour slot 1 over slot 2.
        applyStimulus(4'b0010, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("wd_grant", 4'b0010, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("wd_err", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b0110, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("wd_regrant1", 4'b0010, 1'b0, 2'd0, 1'b1, 1'b1);
        tick();
        checkOutput("wd_ack1", 4'b0000, 1'b1, 2'd1, 1'b1, 1'b1);
        applyStimulus(4'b0100, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("wd_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        checkOutput("wd_grant2", 4'b0100, 1'b0, 2'd0, 1'b1, 1'b1);
        tick();
        checkOutput("wd_ack2", 4'b0000, 1'b1, 2'd2, 1'b1, 1'b1);
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();

        // Slot 3 presents ID 1.
        rst_n = 1'b0;
        tick();
        checkOutput("err_cleared", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(4'b1000, {2'd1, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("id_grant3", 4'b1000, 1'b0, 2'd0, 1'b1, 1'b0);
        tick();
`ifdef MEM_ACK_ID_CHECK_EN
        checkOutput("id_mismatch", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
`else
        checkOutput("id_passthru", 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0);
`endif
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();

        // Reset asserted while the broadcast pulse is high.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(4'b0100, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("rb_grant2", 4'b0100, 1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("rb_ack2", 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0);
        rst_n = 1'b0;
        applyStimulus(4'b0000, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("rb_dropped", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(4'b1001, {2'd3, 2'd2, 2'd1, 2'd0});
        tick();
        checkOutput("rb_ptr0", 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("rb_ack0", 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
